load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, SHALL give the maximum WAIT cycles before a bus timeout.
REQ-002 Parameter ADDR_LIMIT, default 32'h9f, SHALL give the highest legal byte address.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  in  1  reset SHALL be asynchronous and active-low.
REQ-005 req_valid  in  1  CPU access request.
REQ-006 req_ready  out  1  high only in IDLE.
REQ-007 req_write  in  1  1 = store, 0 = load.
REQ-008 req_funct3  in  3  RV32I load/store funct3.
REQ-009 req_addr  in  32  byte address.
REQ-010 req_wdata  in  32  store data, from rs2.
REQ-011 resp_valid  out  1  one-cycle completion pulse.
REQ-012 resp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-013 resp_err  out  2  0 = ok, 1 = misaligned/illegal funct3, 2 = out of range, 3 = timeout.
REQ-014 bus_read, bus_write  out  1 each  one-cycle request strobes to the bus arbiter.
REQ-015 bus_byte_enable  out  4  lane enables.
REQ-016 bus_address  out  10  byte address, req_addr[9:0].
REQ-017 bus_writedata  out  32  lane-replicated store data.
REQ-018 bus_readdata  in  32  arbiter read data.
REQ-019 bus_ready  in  1  one-cycle arbiter completion pulse.

Function
REQ-020 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT, RESP.
REQ-021 IDLE with req_valid=1 SHALL latch all req_* inputs and go to RESP when an error is found at acceptance, otherwise to ISSUE.
REQ-022 Acceptance errors SHALL be checked in this priority order: code 1 first, then code 2; no bus strobe SHALL be issued for either.
REQ-023 Legal funct3 SHALL be: loads 0, 1, 2, 4, 5; stores 0, 1, 2; any other value SHALL give code 1.
REQ-024 Misalignment (halfword with addr[0]=1, or word with addr[1:0]!=0) SHALL give code 1.
REQ-025 req_addr > ADDR_LIMIT SHALL give code 2.
REQ-026 In ISSUE, exactly one of bus_read/bus_write SHALL be 1 for exactly one cycle; the FSM SHALL then go to WAIT.
REQ-027 bus_address, bus_byte_enable and bus_writedata SHALL be stable from ISSUE until the cycle after bus_ready or timeout.
REQ-028 Byte enables SHALL be: byte access 4'b0001<<addr[1:0]; halfword 4'b0011<<addr[1:0]; word 4'b1111.
REQ-029 Store data SHALL be lane-replicated: SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata.
REQ-030 bus_ready SHALL be sampled in both ISSUE and WAIT; when sampled high, the FSM SHALL capture the response and go to RESP.
REQ-031 The WAIT counter SHALL clear on ISSUE entry and increment each WAIT cycle.
REQ-032 When the WAIT counter reaches TIMEOUT_CYCLES with no bus_ready, the FSM SHALL go to RESP with code 3.
REQ-033 bus_ready arriving in the same cycle the counter reaches TIMEOUT_CYCLES SHALL win, giving code 0.
REQ-034 Load extraction SHALL use the latched addr[1:0]: LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
REQ-035 RESP SHALL last one cycle with resp_valid=1, then return to IDLE.
REQ-036 resp_rdata and resp_err SHALL hold their values until the next RESP.
REQ-037 bus_ready received in IDLE or RESP SHALL be ignored.
REQ-038 req_* inputs SHALL be ignored outside IDLE.
REQ-039 Best-case latency SHALL be: accept edge, ISSUE, WAIT cycles, RESP; errors detected at acceptance SHALL reach RESP one cycle after accept.

Reset
REQ-040 rst_n=0 SHALL immediately force state IDLE and clear the WAIT counter.
REQ-041 rst_n=0 SHALL immediately set req_ready=0, every other output to 0, and bus_read/bus_write to 0.
REQ-042 req_ready SHALL become 1 on the first clk edge after rst_n deasserts.
REQ-043 A reset mid-transaction SHALL abort it with no resp_valid pulse.

Verification
REQ-044 LW, addr 0x10; bus_ready after 2 WAIT cycles with readdata 0xDEADBEEF -> one bus_read pulse, byte_enable 4'b1111, resp_rdata 0xDEADBEEF, resp_err 0.
REQ-045 LB, addr 0x13; readdata 0x80FF_0000 -> byte_enable 4'b1000, resp_rdata 0xFFFFFF80; the same access as LBU -> 0x00000080.
REQ-046 SH, addr 0x92, wdata 0x1234ABCD -> bus_write one cycle, byte_enable 4'b1100, writedata 0xABCDABCD, resp_rdata 0.
REQ-047 LW at 0x02 -> code 1; LW at 0xA0 -> code 2; both without any bus strobe, resp_valid one cycle after accept.
REQ-048 SW at 0x84 with bus_ready never asserted -> resp_err 3 after 16 WAIT cycles; repeat with bus_ready on cycle 16 -> resp_err 0.
REQ-049 rst_n low during WAIT -> outputs cleared at once, no resp_valid; next LW completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store sequencer between the CPU request port and a single-beat bus arbiter
module load_store_unit #(
  parameter int          TIMEOUT_CYCLES = 16,
  parameter logic [31:0] ADDR_LIMIT     = 32'h9f
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic        bus_read,
  output logic        bus_write,
  output logic [3:0]  bus_byte_enable,
  output logic [9:0]  bus_address,
  output logic [31:0] bus_writedata,
  input  logic [31:0] bus_readdata,
  input  logic        bus_ready
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t      state;
  logic [CW-1:0] cnt;
  logic [2:0]  f3;
  logic [1:0]  a_lo;
  logic        wr;
  logic        illegal, misal;
  logic [1:0]  acc_err;
  logic [31:0] sh, load_data;
  // acceptance checks: bad funct3 or misalignment outrank an out-of-range address
  always_comb begin
    illegal = req_write ? (req_funct3 > 3'd2) : (req_funct3 == 3'd3 || req_funct3 > 3'd5);
    misal   = (req_funct3[1:0] == 2'd1 && req_addr[0]) || (req_funct3[1:0] == 2'd2 && req_addr[1:0] != 2'b00);
    acc_err = (illegal || misal) ? 2'd1 : (req_addr > ADDR_LIMIT) ? 2'd2 : 2'd0;
  end
  // load lane extraction from the latched byte offset and funct3
  always_comb begin
    sh = bus_readdata >> {a_lo, 3'b000};
    load_data = f3 == 3'd0 ? {{24{sh[7]}}, sh[7:0]} :
                f3 == 3'd1 ? {{16{sh[15]}}, sh[15:0]} :
                f3 == 3'd4 ? {24'b0, sh[7:0]} :
                f3 == 3'd5 ? {16'b0, sh[15:0]} : sh;
  end
  // control FSM; every output is registered, bus fields hold until the next acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      f3              <= '0;
      a_lo            <= '0;
      wr              <= 1'b0;
      req_ready       <= 1'b0;
      resp_valid      <= 1'b0;
      resp_rdata      <= '0;
      resp_err        <= '0;
      bus_read        <= 1'b0;
      bus_write       <= 1'b0;
      bus_byte_enable <= '0;
      bus_address     <= '0;
      bus_writedata   <= '0;
    end else begin
      resp_valid <= 1'b0;
      bus_read   <= 1'b0;
      bus_write  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_ready && req_valid) begin
            req_ready       <= 1'b0;
            f3              <= req_funct3;
            a_lo            <= req_addr[1:0];
            wr              <= req_write;
            cnt             <= '0;
            bus_address     <= req_addr[9:0];
            bus_byte_enable <= req_funct3[1:0] == 2'd0 ? 4'b0001 << req_addr[1:0] :
                               req_funct3[1:0] == 2'd1 ? 4'b0011 << req_addr[1:0] : 4'b1111;
            bus_writedata   <= req_funct3[1:0] == 2'd0 ? {4{req_wdata[7:0]}} :
                               req_funct3[1:0] == 2'd1 ? {2{req_wdata[15:0]}} : req_wdata;
            if (acc_err != 2'd0) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= acc_err;
              resp_rdata <= '0;
            end else begin
              state     <= ISSUE;
              bus_read  <= !req_write;
              bus_write <= req_write;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        ISSUE, WAIT: begin
          if (bus_ready) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 2'd0;
            resp_rdata <= wr ? 32'd0 : load_data;
          end else if (state == WAIT && cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 2'd3;
            resp_rdata <= '0;
          end else begin
            state <= WAIT;
            if (state == WAIT) cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table-driven directed check of load_store_unit plus reset corner sequences
module tb_load_store_unit;
  logic        clk = 0, rst_n = 0;
  logic        req_valid = 0, req_write = 0, bus_ready = 0;
  logic [2:0]  req_funct3 = 0;
  logic [31:0] req_addr = 0, req_wdata = 0, bus_readdata = 0;
  logic        req_ready, resp_valid, bus_read, bus_write;
  logic [31:0] resp_rdata, bus_writedata;
  logic [1:0]  resp_err;
  logic [3:0]  bus_byte_enable;
  logic [9:0]  bus_address;
  int n_vec = 0, n_fail = 0, n_chk = 0;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .bus_read(bus_read), .bus_write(bus_write), .bus_byte_enable(bus_byte_enable),
    .bus_address(bus_address), .bus_writedata(bus_writedata),
    .bus_readdata(bus_readdata), .bus_ready(bus_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, rdata;
    int          rdy, lat;
    logic [1:0]  err;
    logic [31:0] exp_rdata;
    logic [3:0]  be;
    logic [31:0] wd;
    int          nrd, nwr;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run(input int id, input vec_t v);
    int rd, wrc, lat;
    logic stable;
    logic [3:0] be;
    logic [31:0] wd;
    logic [9:0] ad;
    @(negedge clk); bus_ready = 1;
    @(negedge clk); bus_ready = 0;
    chk($sformatf("v%0d idle_bus_ready_ignored", id), {31'b0, resp_valid}, 0);
    chk($sformatf("v%0d req_ready", id), {31'b0, req_ready}, 1);
    req_valid = 1; req_write = v.wr; req_funct3 = v.f3; req_addr = v.addr;
    req_wdata = v.wdata; bus_readdata = v.rdata;
    @(negedge clk);
    req_valid = 0; req_addr = 32'hFFFF_FFFF; req_funct3 = 3'd7; req_wdata = 32'h0BAD_0BAD;
    rd = 0; wrc = 0; lat = -1; stable = 1; be = 0; wd = 0; ad = 0;
    for (int n = 0; n < 40; n++) begin
      rd += int'(bus_read); wrc += int'(bus_write);
      if (n == 0) begin be = bus_byte_enable; wd = bus_writedata; ad = bus_address; end
      else if (bus_byte_enable !== be || bus_writedata !== wd || bus_address !== ad) stable = 0;
      if (resp_valid) begin lat = n; break; end
      bus_ready = (v.rdy == n);
      @(negedge clk);
      bus_ready = 0;
    end
    chk($sformatf("v%0d latency", id), lat, v.lat);
    chk($sformatf("v%0d resp_err", id), {30'b0, resp_err}, {30'b0, v.err});
    chk($sformatf("v%0d resp_rdata", id), resp_rdata, v.exp_rdata);
    chk($sformatf("v%0d bus_read_pulses", id), rd, v.nrd);
    chk($sformatf("v%0d bus_write_pulses", id), wrc, v.nwr);
    if (v.nrd + v.nwr > 0) begin
      chk($sformatf("v%0d byte_enable", id), {28'b0, be}, {28'b0, v.be});
      chk($sformatf("v%0d bus_address", id), {22'b0, ad}, {22'b0, v.addr[9:0]});
      chk($sformatf("v%0d bus_fields_stable", id), {31'b0, stable}, 1);
    end
    if (v.nwr > 0) chk($sformatf("v%0d writedata", id), wd, v.wd);
    @(negedge clk);
    chk($sformatf("v%0d resp_valid_one_cycle", id), {31'b0, resp_valid}, 0);
    chk($sformatf("v%0d rdata_held", id), resp_rdata, v.exp_rdata);
    chk($sformatf("v%0d err_held", id), {30'b0, resp_err}, {30'b0, v.err});
    n_vec++;
  endtask

  initial begin
    //           wr f3    addr      wdata         rdata         rdy lat err exp_rdata     be       wd            nrd nwr
    vecs[0]  = '{0, 3'd2, 32'h10, 32'h0,        32'hDEADBEEF, 2,  3,  0, 32'hDEADBEEF, 4'b1111, 32'h0,        1, 0};
    vecs[1]  = '{0, 3'd0, 32'h13, 32'h0,        32'h80FF0000, 0,  1,  0, 32'hFFFFFF80, 4'b1000, 32'h0,        1, 0};
    vecs[2]  = '{0, 3'd4, 32'h13, 32'h0,        32'h80FF0000, 1,  2,  0, 32'h00000080, 4'b1000, 32'h0,        1, 0};
    vecs[3]  = '{1, 3'd1, 32'h92, 32'h1234ABCD, 32'h55555555, 1,  2,  0, 32'h0,        4'b1100, 32'hABCDABCD, 0, 1};
    vecs[4]  = '{0, 3'd2, 32'h02, 32'h0,        32'h0,        -1, 0,  1, 32'h0,        4'b0000, 32'h0,        0, 0};
    vecs[5]  = '{0, 3'd2, 32'hA0, 32'h0,        32'h0,        -1, 0,  2, 32'h0,        4'b0000, 32'h0,        0, 0};
    vecs[6]  = '{1, 3'd2, 32'h84, 32'h11223344, 32'h0,        -1, 17, 3, 32'h0,        4'b1111, 32'h11223344, 0, 1};
    vecs[7]  = '{1, 3'd2, 32'h84, 32'h11223344, 32'hAAAAAAAA, 16, 17, 0, 32'h0,        4'b1111, 32'h11223344, 0, 1};
    vecs[8]  = '{1, 3'd2, 32'h88, 32'hCAFEF00D, 32'h0,        15, 16, 0, 32'h0,        4'b1111, 32'hCAFEF00D, 0, 1};
    vecs[9]  = '{0, 3'd1, 32'h22, 32'h0,        32'h80017FFF, 0,  1,  0, 32'hFFFF8001, 4'b1100, 32'h0,        1, 0};
    vecs[10] = '{0, 3'd5, 32'h22, 32'h0,        32'h80017FFF, 3,  4,  0, 32'h00008001, 4'b1100, 32'h0,        1, 0};
    vecs[11] = '{1, 3'd0, 32'h41, 32'h000000A5, 32'h0,        2,  3,  0, 32'h0,        4'b0010, 32'hA5A5A5A5, 0, 1};
    vecs[12] = '{0, 3'd3, 32'h10, 32'h0,        32'h0,        -1, 0,  1, 32'h0,        4'b0000, 32'h0,        0, 0};
    vecs[13] = '{1, 3'd4, 32'h10, 32'h0,        32'h0,        -1, 0,  1, 32'h0,        4'b0000, 32'h0,        0, 0};
    vecs[14] = '{0, 3'd1, 32'h23, 32'h0,        32'h0,        -1, 0,  1, 32'h0,        4'b0000, 32'h0,        0, 0};
    vecs[15] = '{0, 3'd2, 32'hA1, 32'h0,        32'h0,        -1, 0,  1, 32'h0,        4'b0000, 32'h0,        0, 0};
    vecs[16] = '{0, 3'd0, 32'hA0, 32'h0,        32'h0,        -1, 0,  2, 32'h0,        4'b0000, 32'h0,        0, 0};
    vecs[17] = '{0, 3'd1, 32'h20, 32'h0,        32'h1234F00F, 0,  1,  0, 32'hFFFFF00F, 4'b0011, 32'h0,        1, 0};
    vecs[18] = '{0, 3'd0, 32'h9F, 32'h0,        32'h7F000000, 4,  5,  0, 32'h0000007F, 4'b1000, 32'h0,        1, 0};

    repeat (2) @(negedge clk);
    chk("reset req_ready", {31'b0, req_ready}, 0);
    chk("reset resp_valid", {31'b0, resp_valid}, 0);
    chk("reset bus_strobes", {30'b0, bus_read, bus_write}, 0);
    rst_n = 1;
    chk("req_ready_before_first_edge", {31'b0, req_ready}, 0);
    @(negedge clk);
    chk("req_ready_after_first_edge", {31'b0, req_ready}, 1);

    for (int i = 0; i < 19; i++) run(i, vecs[i]);

    @(negedge clk);
    req_valid = 1; req_write = 0; req_funct3 = 3'd2; req_addr = 32'h10; bus_readdata = 32'h0;
    @(negedge clk); req_valid = 0;
    repeat (3) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("midreset req_ready", {31'b0, req_ready}, 0);
    chk("midreset strobes", {30'b0, bus_read, bus_write}, 0);
    chk("midreset bus_address", {22'b0, bus_address}, 0);
    chk("midreset byte_enable", {28'b0, bus_byte_enable}, 0);
    chk("midreset resp_rdata", resp_rdata, 0);
    chk("midreset resp_err", {30'b0, resp_err}, 0);
    begin
      int seen = 0;
      for (int i = 0; i < 25; i++) begin
        @(negedge clk);
        if (i == 3) rst_n = 1;
        seen += int'(resp_valid);
      end
      chk("midreset no_resp_valid", seen, 0);
    end
    run(100, vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
